// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the load/store writeback unit: funct3 values, RF write codes,
// error codes and FSM state encoding, plus small decode helpers.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] WE3_NONE = 3'd0;
    localparam logic [2:0] WE3_LW   = 3'd1;
    localparam logic [2:0] WE3_LB   = 3'd2;
    localparam logic [2:0] WE3_LH   = 3'd3;
    localparam logic [2:0] WE3_LBU  = 3'd4;
    localparam logic [2:0] WE3_LHU  = 3'd5;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Unsigned byte/half variants only exist for loads.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return |lo;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] we3_code(input logic [2:0] f3);
        case (f3)
            F3_W:    return WE3_LW;
            F3_B:    return WE3_LB;
            F3_H:    return WE3_LH;
            F3_BU:   return WE3_LBU;
            F3_HU:   return WE3_LHU;
            default: return WE3_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_writeback_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface lsu_writeback_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication/byte strobes and load right-alignment.
// Zero latency; no flow control of its own.
module lsu_align (
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] sdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data
);

    always_comb begin
        st_wdata = sdata;
        st_wstrb = 4'b1111;
        case (st_size)
            2'b00: begin
                st_wdata = {4{sdata[7:0]}};
                st_wstrb = 4'b0001 << st_addr_lo;
            end
            2'b01: begin
                st_wdata = {2{sdata[15:0]}};
                st_wstrb = 4'b0011 << st_addr_lo;
            end
            default: begin
                st_wdata = sdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Extension is the register file's job; only shift the addressed lane down.
    assign ld_data = rdata >> {ld_addr_lo, 3'b000};

endmodule

// File: rtl/lsu_writeback.sv
// Load/store unit: one memory transaction per start, load data right-aligned to the RF port.
// Latency: mem_req the cycle after start; done/rf_we3 the cycle after mem_ack; errors done next cycle.
// Backpressure: mem_req held until mem_ack or timeout; start ignored while busy.
module lsu_writeback
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   is_store,
    input  logic [2:0]             funct3,
    input  logic [31:0]            addr,
    input  logic [31:0]            sdata,
    input  logic [4:0]             rd,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err,
    lsu_writeback_if.master        mem,
    output logic [4:0]             rf_a3,
    output logic [31:0]            rf_wd3,
    output logic [2:0]             rf_we3
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_store_q, is_store_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [4:0]       rd_q, rd_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic [4:0]       rf_a3_q, rf_a3_d;
    logic [31:0]      rf_wd3_q, rf_wd3_d;
    logic [2:0]       rf_we3_q, rf_we3_d;

    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [31:0]      ld_data;

    // Store lanes come from the live request inputs; load shift uses the latched offset.
    lsu_align u_align (
        .st_size    (funct3[1:0]),
        .st_addr_lo (addr[1:0]),
        .sdata      (sdata),
        .ld_addr_lo (addr_lo_q),
        .rdata      (mem.mem_rdata),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .ld_data    (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        rd_d        = rd_q;
        done_d      = 1'b0;
        err_d       = ERR_OK;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        rf_a3_d     = '0;
        rf_wd3_d    = '0;
        rf_we3_d    = WE3_NONE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_lo_d  = addr[1:0];
                    rd_d       = rd;
                    if (!f3_legal(is_store, funct3)) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = ERR_ILLEGAL;
                    end else if (f3_misaligned(funct3, addr[1:0])) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = ERR_MISALIGN;
                    end else begin
                        state_d    = ST_REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = is_store;
                        mem_addr_d = {addr[31:2], 2'b00};
                        if (is_store) begin
                            mem_wdata_d = st_wdata;
                            mem_wstrb_d = st_wstrb;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    state_d = ST_WB;
                    done_d  = 1'b1;
                    // x0 is never written; the register file relies on this.
                    if (!is_store_q && (rd_q != 5'd0)) begin
                        rf_a3_d  = rd_q;
                        rf_wd3_d = ld_data;
                        rf_we3_d = we3_code(funct3_q);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                    mem_wstrb_d = mem_wstrb_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            rd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rf_a3_q     <= '0;
            rf_wd3_q    <= '0;
            rf_we3_q    <= WE3_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rf_a3_q     <= rf_a3_d;
            rf_wd3_q    <= rf_wd3_d;
            rf_we3_q    <= rf_we3_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;
    assign rf_a3         = rf_a3_q;
    assign rf_wd3        = rf_wd3_q;
    assign rf_we3        = rf_we3_q;

endmodule
